mlp_param_loader: RTL
=====================

Name: mlp_param_loader

Overview:
- Streaming writer that fills the weight and bias operands of an mlp_layer instance.
- Accepts a valid/ready word stream from the host or SPI bridge and stores D1*D2 weights, then D2 biases, in registers.
- Drives those registers directly onto the layer's weights/biases inputs and flags when the parameter set is complete and stable.
- One loader per layer instance; the downstream layer output is used only while params_valid=1.

Parameters:
- NBits, 16, word width; equals the mlp_layer NBits.
- D1, 4, layer input dimension (weight rows).
- D2, 3, layer output dimension (weight columns, bias count).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a new load sequence
- in_data  input  NBits  parameter word
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts in_data this cycle
- weights  output  NBits x [D1][D2]  registered weight array to mlp_layer
- biases  output  NBits x [D2]  registered bias array to mlp_layer
- params_valid  output  1  full parameter set loaded and stable
- busy  output  1  load sequence in progress
- load_done  output  1  one-cycle pulse when the final bias is stored

Behaviour:
- Reset (async assert, sync deassert at flops):
  - All weights and biases = 0.
  - params_valid=0, busy=0, in_ready=0, load_done=0.
  - FSM enters IDLE.
- FSM states: IDLE, LOAD_W, LOAD_B, DONE.
- IDLE/DONE:
  - On start=1, go to LOAD_W next cycle; clear params_valid and the i/j counters.
  - in_valid is ignored in these states.
- Handshake:
  - in_ready = (state==LOAD_W or LOAD_B) and !start.
  - A word is accepted on a rising clk with in_valid and in_ready both 1.
  - in_valid without in_ready has no effect; there is no internal buffering.
- LOAD_W:
  - An accepted word is written to weights[i][j].
  - Order is row-major: j increments 0..D2-1; at wrap, j=0 and i++.
  - Accepting weights[D1-1][D2-1] moves the FSM to LOAD_B with bias index b=0.
- LOAD_B:
  - An accepted word is written to biases[b]; b increments.
  - Accepting biases[D2-1] moves the FSM to DONE.
  - The same edge produces load_done=1 for exactly one cycle and sets params_valid=1, both visible in the cycle after the last handshake.
- busy = state in {LOAD_W, LOAD_B}.
- Register contents:
  - Words are copied unmodified; no sign or width conversion.
  - Registers not yet rewritten in the current sequence keep their previous values.
  - params_valid stays 0 until the whole sequence completes.
- start while busy: restart.
  - Counters i/j/b reset to 0, the state returns to LOAD_W, and params_valid stays 0.
  - No word is accepted in the start cycle, because in_ready is forced to 0.
- Latency: D1*D2+D2 accepted words, then 1 cycle to params_valid. With back-to-back valid, in_ready stays high continuously, except in the start cycle and in DONE.
- Reset mid-load: everything returns to reset values immediately; a partial set is never flagged valid.
- Counter widths: $clog2 of each dimension, minimum 1 bit; no wrap beyond the last index.

Test Plan (bench parameters D1=2, D2=3, NBits=16):
- Reset with in_valid=1 held → in_ready=0, all outputs 0, params_valid=0 throughout reset and in IDLE.
- start, then words 1..9 back-to-back →
  - weights = {{1,2,3},{4,5,6}}, biases = {7,8,9}.
  - load_done pulses exactly once, one cycle after word 9.
  - params_valid=1 from that cycle; busy drops the same cycle.
- Same load with in_valid toggled randomly (50%) → identical final arrays; no word is duplicated or skipped.
- After a complete load, start, feed words 0xA..0xC, then start again, then words 0x10..0x18 →
  - Final weights = {{0x10,0x11,0x12},{0x13,0x14,0x15}}, biases = {0x16,0x17,0x18}.
  - params_valid=0 from the first start until completion.
- rst_n pulsed low after 4 words accepted → immediate clear to all zeros, params_valid=0, state IDLE; words presented after reset with no start are ignored.
- start asserted in the same cycle as in_valid=1 during LOAD_B → that word is not accepted (in_ready=0); indices restart at weights[0][0].

Source files
------------

// File: rtl/mlp_param_loader.sv
// ---------------------------------------------------------------------------
// mlp_param_loader
//   Streaming parameter writer for one mlp_layer instance. Accepts a
//   valid/ready word stream and stores D1*D2 weights (row-major) followed by
//   D2 biases in registers that drive the layer operands directly.
//   params_valid rises only once a complete sequence has been stored and
//   stays low from any start until the next completion.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         single-cycle request to begin (or restart) a load sequence
//   in_data       parameter word
//   in_valid      in_data valid
//   in_ready      loader accepts in_data this cycle (combinational)
//   weights       registered weight array [D1][D2] to mlp_layer
//   biases        registered bias array [D2] to mlp_layer
//   params_valid  full parameter set loaded and stable
//   busy          load sequence in progress
//   load_done     one-cycle pulse after the final bias is stored
// ---------------------------------------------------------------------------
module mlp_param_loader #(
  parameter int unsigned NBits = 16,
  parameter int unsigned D1    = 4,
  parameter int unsigned D2    = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [NBits-1:0]                   in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [D1-1:0][D2-1:0][NBits-1:0]   weights,
  output logic [D2-1:0][NBits-1:0]           biases,
  output logic                               params_valid,
  output logic                               busy,
  output logic                               load_done
);

  // Index widths, at least one bit even for single-entry dimensions
  localparam int unsigned IW = (D1 > 1) ? $clog2(D1) : 1;
  localparam int unsigned JW = (D2 > 1) ? $clog2(D2) : 1;
  localparam int unsigned BW = (D2 > 1) ? $clog2(D2) : 1;

  localparam logic [IW-1:0] ROW_LAST  = IW'(D1 - 1);
  localparam logic [JW-1:0] COL_LAST  = JW'(D2 - 1);
  localparam logic [BW-1:0] BIAS_LAST = BW'(D2 - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [IW-1:0]   row;
  logic [JW-1:0]   col;
  logic [BW-1:0]   bidx;

  logic            loading;
  logic            accept;
  logic            last_col;
  logic            last_row;
  logic            last_bias;
  logic            w_we;
  logic            b_we;
  logic            done_set;

  // Handshake: ready only while loading, and never in a start cycle
  always_comb begin
    loading   = (state == LOAD_W) || (state == LOAD_B);
    in_ready  = loading && !start;
    accept    = in_valid && in_ready;
    last_col  = (col == COL_LAST);
    last_row  = (row == ROW_LAST);
    last_bias = (bidx == BIAS_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and write strobes; start always wins and restarts at LOAD_W
  always_comb begin
    state_nxt = state;
    w_we      = 1'b0;
    b_we      = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = LOAD_W;
        end
      end
      LOAD_W: begin
        if (start) begin
          state_nxt = LOAD_W;
        end else if (accept) begin
          w_we = 1'b1;
          if (last_col && last_row) begin
            state_nxt = LOAD_B;
          end
        end
      end
      LOAD_B: begin
        if (start) begin
          state_nxt = LOAD_W;
        end else if (accept) begin
          b_we = 1'b1;
          if (last_bias) begin
            state_nxt = DONE;
            done_set  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Write indices: row-major weight walk, then bias walk; no wrap past the end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      bidx <= '0;
    end else if (start) begin
      row  <= '0;
      col  <= '0;
      bidx <= '0;
    end else if (w_we) begin
      if (last_col) begin
        col <= '0;
        if (last_row) begin
          row  <= '0;
          bidx <= '0;
        end else begin
          row <= row + IW'(1);
        end
      end else begin
        col <= col + JW'(1);
      end
    end else if (b_we) begin
      if (!last_bias) begin
        bidx <= bidx + BW'(1);
      end
    end
  end

  // Parameter registers; untouched entries hold their previous contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights <= '0;
      biases  <= '0;
    end else begin
      if (w_we) begin
        weights[row][col] <= in_data;
      end
      if (b_we) begin
        biases[bidx] <= in_data;
      end
    end
  end

  // Status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      params_valid <= 1'b0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      load_done <= done_set;
      busy      <= (state_nxt == LOAD_W) || (state_nxt == LOAD_B);
      if (start) begin
        params_valid <= 1'b0;
      end else if (done_set) begin
        params_valid <= 1'b1;
      end
    end
  end

endmodule
